// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/bubble merge with registered flush sequencer
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int STAGES       = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic              flush_busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);
    localparam int         IDX_W    = (STAGES > 2) ? $clog2(STAGES) : 1;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] mask_q, mask_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  src_q, src_d;

    logic              stall_any, flush_any, accept;
    logic [IDX_W-1:0]  stall_k, flush_m;
    logic [STAGES-1:0] stall_raw, bubble_raw, flush_new_mask;

    always_comb begin
        stall_any = 1'b0;
        stall_k   = '0;
        flush_any = 1'b0;
        flush_m   = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (stall_req[i]) begin
                stall_any = 1'b1;
                stall_k   = IDX_W'(i);
            end
        end
        // bit 0 cannot redirect: nothing is younger than the PC stage
        for (int i = 1; i < STAGES; i++) begin
            if (flush_req[i]) begin
                flush_any = 1'b1;
                flush_m   = IDX_W'(i);
            end
        end
        stall_raw      = '0;
        bubble_raw     = '0;
        flush_new_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (stall_any && (IDX_W'(i) <= stall_k))      stall_raw[i]      = 1'b1;
            if (stall_any && (i == int'(stall_k) + 1))    bubble_raw[i]     = 1'b1;
            if (flush_any && (IDX_W'(i) < flush_m))       flush_new_mask[i] = 1'b1;
        end
    end

    // A request from an older stage supersedes the running flush; younger ones are already covered
    assign accept = rdy && flush_any && ((state_q == IDLE) || (flush_m > src_q));

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        if (accept) begin
            state_d = FLUSH;
            mask_d  = flush_new_mask;
            cnt_d   = CNT_INIT;
            src_d   = flush_m;
        end else if (rdy && (state_q == FLUSH)) begin
            if (cnt_q == 4'd0) begin
                state_d = IDLE;
                mask_d  = '0;
                src_d   = '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        stall  = '0;
        bubble = '0;
        flush  = '0;
        if (rst) begin
            if (!rdy) begin
                stall = '1;
            end else begin
                flush  = (state_q == FLUSH) ? mask_q : '0;
                stall  = stall_raw & ~flush;
                bubble = bubble_raw & ~flush;
            end
        end
    end

    assign flush_busy = (state_q == FLUSH);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (rdy && (|stall) && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (accept && (flush_events_q != {CNT_W{1'b1}}))
            flush_events_d = flush_events_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int STAGES       = 6;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 5;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [STAGES-1:0] stall_req, flush_req;
    logic [STAGES-1:0] stall, bubble, flush;
    logic              flush_busy;
    logic [CNT_W-1:0]  stall_cycles, flush_events;

    int n_checks = 0;
    int n_errors = 0;

    // model: source stage of the active flush and how many visible cycles remain
    int               m_src  = 0;
    int               m_left = 0;
    logic [CNT_W-1:0] m_sc   = '0;
    logic [CNT_W-1:0] m_fe   = '0;

    pipe_hazard_ctrl #(
        .STAGES(STAGES), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .stall_req(stall_req), .flush_req(flush_req),
        .stall(stall), .bubble(bubble), .flush(flush),
        .flush_busy(flush_busy),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int highest(input logic [STAGES-1:0] v);
        int h = -1;
        for (int i = 0; i < STAGES; i++) if (v[i]) h = i;
        return h;
    endfunction

    function automatic logic [STAGES-1:0] low_ones(input int n);
        return STAGES'((1 << n) - 1);
    endfunction

    task automatic model_reset();
        m_src  = 0;
        m_left = 0;
        m_sc   = '0;
        m_fe   = '0;
    endtask

    // drive one cycle, check every output against the model, then advance the model over the edge
    task automatic step(input logic r, input logic [STAGES-1:0] sr, input logic [STAGES-1:0] fr);
        int k, m;
        bit acc;
        logic [STAGES-1:0] e_fl, e_st, e_bu;
        @(posedge clk);
        #1;
        rdy = r; stall_req = sr; flush_req = fr;
        #3;
        k = highest(sr);
        m = highest(fr & ~STAGES'(1));
        e_fl = (r && m_left > 0) ? low_ones(m_src) : '0;
        if (!r) begin
            e_st = '1;
            e_bu = '0;
        end else begin
            e_st = (k >= 0) ? low_ones(k + 1) : '0;
            e_bu = (k >= 0 && k < STAGES - 1) ? STAGES'(1 << (k + 1)) : '0;
            e_st = e_st & ~e_fl;
            e_bu = e_bu & ~e_fl;
        end
        chk("stall", 32'(stall), 32'(e_st));
        chk("bubble", 32'(bubble), 32'(e_bu));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("flush_busy", 32'(flush_busy), 32'(m_left > 0));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        chk("flush_events", 32'(flush_events), 32'(m_fe));
        if (r) begin
            acc = (m > 0) && (m_left == 0 || m > m_src);
`ifdef PIPE_PERF_CNT_EN
            if (e_st != '0 && m_sc != CMAX) m_sc = m_sc + 1'b1;
            if (acc && m_fe != CMAX) m_fe = m_fe + 1'b1;
`endif
            if (acc) begin
                m_src  = m;
                m_left = FLUSH_CYCLES;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end
        end
    endtask

    initial begin
        logic [CNT_W-1:0] fe_before;
        logic [CNT_W-1:0] sat_exp;
        rst = 1'b0; rdy = 1'b1; stall_req = '1; flush_req = '0;
        #3;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_busy", 32'(flush_busy), 32'd0);
        @(posedge clk); #2 rst = 1'b1;
        model_reset();

        // T1: stall from stage 2
        step(1'b1, 6'b000100, 6'b000000);
        chk("t1_stall", 32'(stall), 32'h07);
        chk("t1_bubble", 32'(bubble), 32'h08);
        chk("t1_flush", 32'(flush), 32'h00);

        // T2: redirect from stage 3 held for two cycles
        step(1'b1, 6'b000000, 6'b001000);
        chk("t2_busy_t", 32'(flush_busy), 32'd0);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t2_flush_t1", 32'(flush), 32'h07);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t2_flush_t2", 32'(flush), 32'h07);
        chk("t2_busy_t2", 32'(flush_busy), 32'd1);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t2_flush_t3", 32'(flush), 32'h00);
        chk("t2_busy_t3", 32'(flush_busy), 32'd0);

        // T3a: older source supersedes and restarts the hold
        step(1'b1, 6'b000000, 6'b001000);
        step(1'b1, 6'b000000, 6'b000000);
        step(1'b1, 6'b000000, 6'b010000);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t3_relatch", 32'(flush), 32'h0F);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t3_relatch2", 32'(flush), 32'h0F);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t3_done", 32'(flush), 32'h00);

        // T3b: younger source while flushing is ignored
        step(1'b1, 6'b000000, 6'b001000);
        fe_before = m_fe;
        step(1'b1, 6'b000000, 6'b000100);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t3_ignored_flush", 32'(flush), 32'h07);
        chk("t3_ignored_events", 32'(flush_events), 32'(fe_before));
        step(1'b1, 6'b000000, 6'b000000);
        chk("t3_ignored_end", 32'(flush), 32'h00);

        // T4: stall and flush in the same cycle
        step(1'b1, 6'b010000, 6'b001000);
        step(1'b1, 6'b010000, 6'b000000);
        chk("t4_stall", 32'(stall), 32'h18);
        chk("t4_flush", 32'(flush), 32'h07);
        chk("t4_bubble", 32'(bubble), 32'h20);
        step(1'b1, 6'b000000, 6'b000000);
        step(1'b1, 6'b000000, 6'b000000);

        // T5: freeze during a flush, then finish the remaining cycle
        step(1'b1, 6'b000000, 6'b001000);
        step(1'b1, 6'b000000, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'b000001, 6'b100000);
            chk("t5_frozen_stall", 32'(stall), 32'h3F);
            chk("t5_frozen_flush", 32'(flush), 32'h00);
        end
        step(1'b1, 6'b000000, 6'b000000);
        chk("t5_resume", 32'(flush), 32'h07);
        step(1'b1, 6'b000000, 6'b000000);
        chk("t5_end", 32'(flush), 32'h00);

        // T6: async reset in the middle of a flush
        step(1'b1, 6'b000010, 6'b100000);
        step(1'b1, 6'b000010, 6'b000000);
        stall_req = '1;
        rst = 1'b0;
        #1;
        chk("t6_stall", 32'(stall), 32'd0);
        chk("t6_flush", 32'(flush), 32'd0);
        chk("t6_bubble", 32'(bubble), 32'd0);
        chk("t6_busy", 32'(flush_busy), 32'd0);
        chk("t6_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("t6_flush_events", 32'(flush_events), 32'd0);
        @(posedge clk); #2 rst = 1'b1;
        model_reset();
        step(1'b1, 6'b000000, 6'b000000);
        chk("t6_no_residual", 32'(flush), 32'd0);

        // random traffic, long enough to saturate the small counters
        for (int n = 0; n < 400; n++) begin
            logic              r;
            logic [STAGES-1:0] sr, fr;
            r  = ($urandom_range(0, 9) != 0);
            sr = ($urandom_range(0, 3) == 0) ? '0 : STAGES'($urandom);
            case ($urandom_range(0, 5))
                0:       fr = STAGES'($urandom);
                1:       fr = STAGES'(1 << $urandom_range(0, STAGES - 1));
                default: fr = '0;
            endcase
            step(r, sr, fr);
        end

`ifdef PIPE_PERF_CNT_EN
        sat_exp = CMAX;
`else
        sat_exp = '0;
`endif
        step(1'b1, 6'b000001, 6'b000000);
        step(1'b1, 6'b000001, 6'b000000);
        chk("t6_saturated", 32'(stall_cycles), 32'(sat_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
